// File: rtl/fixed_64_accum_pkg.sv
// Shared definitions for the Q8.8 multiply-accumulate engine and its
// downstream Q56.8 -> Q8.8 clamp: operand/result widths, fractional
// bit count and the engine's state encoding.
package fixed_64_accum_pkg;

    localparam int Q88_W     = 16;          // signed Q8.8 operand width
    localparam int PROD_W    = 2 * Q88_W;   // signed Q16.16 exact product width
    localparam int Q568_W    = 64;          // signed Q56.8 accumulator width
    localparam int FRAC_BITS = 8;           // fractional bits of Q8.8 / Q56.8

    // Engine states:
    //   ST_IDLE  - no terms pending, accepting the first pair of a vector
    //   ST_ACCUM - at least one term accepted, last not yet seen
    //   ST_DRAIN - last accepted, product/accumulate pipeline emptying
    //   ST_DONE  - result offered on the output port
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } accum_state_e;

endpackage

// File: rtl/fixed_16_mul_q.sv
// Registered 16x16 signed Q8.8 multiplier. The exact Q16.16 product is
// held in a register and aligned to a Q56.8 term on its output:
// arithmetic shift right by the fractional bit count, sign-extended.
// Build option FIXED_ACCUM_ROUND_EN: add half an LSB before the shift
// (round-half-up); otherwise the shift truncates toward minus infinity.
module fixed_16_mul_q
    import fixed_64_accum_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic signed [Q88_W-1:0]  i_a,
    input  logic signed [Q88_W-1:0]  i_b,
    output logic                     o_valid,
    output logic                     o_last,
    output logic [Q568_W-1:0]        o_term
);

    logic signed [PROD_W-1:0] r_p;
    logic                     r_valid;
    logic                     r_last;

    logic signed [Q568_W-1:0] w_p_ext;
    logic signed [Q568_W-1:0] w_biased;

    // Capture the exact product of every accepted pair, tagged with valid/last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p     <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_valid <= i_valid;
            r_last  <= i_valid & i_last;
            if (i_valid) begin
                r_p <= i_a * i_b;
            end
        end
    end

    assign w_p_ext = {{(Q568_W - PROD_W){r_p[PROD_W-1]}}, r_p};

`ifdef FIXED_ACCUM_ROUND_EN
    // Half an output LSB; the product magnitude never exceeds 2^30 so the
    // bias cannot carry out of the sign-extended value.
    localparam logic signed [Q568_W-1:0] ROUND_BIAS = 64'sd128;
    assign w_biased = w_p_ext + ROUND_BIAS;
`else
    assign w_biased = w_p_ext;
`endif

    assign o_term  = w_biased >>> FRAC_BITS;
    assign o_valid = r_valid;
    assign o_last  = r_last;

endmodule

// File: rtl/fixed_64_accum.sv
// Sequential Q8.8 multiply-accumulate engine producing Q56.8 sums.
// Build option FIXED_ACCUM_ROUND_EN selects round-half-up term alignment
// (inside fixed_16_mul_q); default is floor. Timing is identical.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. in_valid/in_a/in_b/in_last must be held until
// accepted; out_valid/out_acc/out_count are held until out_ready.
//
// Pipeline: last beat accepted at edge t -> product registered at t,
// term added to the accumulator at t+1, result registered and out_valid
// raised at t+2.
module fixed_64_accum
    import fixed_64_accum_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [Q88_W-1:0]     in_a,
    input  logic [Q88_W-1:0]     in_b,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [Q568_W-1:0]    out_acc,
    output logic [CNT_W-1:0]     out_count,
    output logic [1:0]           o_dbg_state
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    accum_state_e        r_state;
    logic [Q568_W-1:0]   r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_first;
    logic                r_sum_done;

    logic                w_beat;
    logic                w_term_valid;
    logic                w_term_last;
    logic [Q568_W-1:0]   w_term;

    assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
    assign w_beat      = in_valid & in_ready;
    assign o_dbg_state = r_state;

    fixed_16_mul_q u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (w_beat),
        .i_last  (in_last),
        .i_a     (in_a),
        .i_b     (in_b),
        .o_valid (w_term_valid),
        .o_last  (w_term_last),
        .o_term  (w_term)
    );

    // Accumulate aligned terms; the first term of a vector overwrites the
    // running sum and restarts the saturating term count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_first    <= 1'b1;
            r_sum_done <= 1'b0;
        end else begin
            r_sum_done <= w_term_valid & w_term_last;
            if (w_term_valid) begin
                r_first <= w_term_last;
                if (r_first) begin
                    r_acc <= w_term;
                    r_cnt <= CNT_ONE;
                end else begin
                    r_acc <= r_acc + w_term;
                    if (!(&r_cnt)) begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

    // Control FSM with registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            out_valid <= 1'b0;
            out_acc   <= '0;
            out_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_beat) begin
                        r_state <= in_last ? ST_DRAIN : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_beat && in_last) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_sum_done) begin
                        r_state   <= ST_DONE;
                        out_valid <= 1'b1;
                        out_acc   <= r_acc;
                        out_count <= r_cnt;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state   <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_64_accum.sv
// Self-checking bench for fixed_64_accum: directed vectors from the
// datasheet examples plus randomized vectors, compared against a
// behavioural reference built on plain integer arithmetic.
module tb_fixed_64_accum;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_acc;
    logic [15:0] out_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] exp_q[$];
    logic [63:0] cnt_q[$];
    logic [15:0] va[$];
    logic [15:0] vb[$];

    fixed_64_accum #(.CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_acc     (out_acc),
        .out_count   (out_count),
        .o_dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%016h exp=0x%016h", tag, got, exp);
        end
    endtask

    // Reference: real-valued product a*b (in units of 2^-16) divided by 256
    // with floor, optionally after adding one half.
    function automatic longint model_term(input logic [15:0] a, input logic [15:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
`ifdef FIXED_ACCUM_ROUND_EN
        p = p + 128;
`endif
        if (p >= 0) return p / 256;
        else        return -((-p + 255) / 256);
    endfunction

    task automatic model_vector();
        longint s = 0;
        foreach (va[i]) s += model_term(va[i], vb[i]);
        exp_q.push_back(64'(s));
        cnt_q.push_back((va.size() > 65535) ? 64'hFFFF : 64'(va.size()));
    endtask

    // driver: called and returns at posedge+1; leaves the beat on the bus
    // until the edge that accepts it.
    task automatic drive_beat(input logic [15:0] a, input logic [15:0] b,
                              input logic last, input int gap_max);
        int g;
        int w;
        g = $urandom_range(0, gap_max);
        if (g > 0) begin
            in_valid = 1'b0;
            repeat (g) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        w = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            w++;
            if (w > 100) begin
                check("in_ready_timeout", 64'(in_ready), 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Send va/vb as one vector, check latency and result, optionally stall
    // the output for 'hold' cycles, then complete the result handshake.
    task automatic run_vec(input string tag, input int gap_max, input int hold);
        int lat;
        logic [63:0] e_acc;
        logic [63:0] e_cnt;
        model_vector();
        foreach (va[i]) drive_beat(va[i], vb[i], (i == va.size() - 1), gap_max);
        in_valid = 1'b0;
        in_last  = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
            if (lat > 50) break;
        end
        check({tag, "_latency"}, 64'(lat), 64'd2);
        e_acc = exp_q.pop_front();
        e_cnt = cnt_q.pop_front();
        check({tag, "_acc"}, out_acc, e_acc);
        check({tag, "_count"}, 64'(out_count), e_cnt);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check({tag, "_hold_in_ready"}, 64'(in_ready), 64'd0);
            check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
            check({tag, "_hold_acc"}, out_acc, e_acc);
            check({tag, "_hold_count"}, 64'(out_count), e_cnt);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_post_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_post_in_ready"}, 64'(in_ready), 64'd1);
        check({tag, "_post_acc_held"}, out_acc, e_acc);
        va.delete();
        vb.delete();
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        va.push_back(a);
        vb.push_back(b);
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_acc", out_acc, 64'd0);
        check("reset_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd1);

        // 1.5 * 2.0 = 3.0
        push_pair(16'h0180, 16'h0200);
        run_vec("single", 0, 0);

        // -0.5 alone, then -0.5 + 1.0
        push_pair(16'hFF00, 16'h0080);
        run_vec("neg_half", 0, 0);
        push_pair(16'hFF00, 16'h0080);
        push_pair(16'h0100, 16'h0100);
        run_vec("two_beat", 0, 0);

        // sub-LSB products: truncation / rounding behaviour
        push_pair(16'h0001, 16'h0080);
        run_vec("tiny_pos", 0, 0);
        push_pair(16'hFFFF, 16'h0001);
        run_vec("tiny_neg", 0, 0);

        // most negative operands, four times
        repeat (4) push_pair(16'h8000, 16'h8000);
        run_vec("max_sq", 0, 0);

        // output stall for 10 cycles, then a clean next vector
        push_pair(16'h0300, 16'hFE80);
        push_pair(16'h0040, 16'h0040);
        run_vec("stall", 0, 10);
        push_pair(16'h7FFF, 16'h7FFF);
        run_vec("after_stall", 1, 0);

        // reset after 3 of 5 beats: nothing emitted, state discarded
        drive_beat(16'h0200, 16'h0200, 1'b0, 0);
        drive_beat(16'h0300, 16'h0100, 1'b0, 0);
        drive_beat(16'h0100, 16'h0500, 1'b0, 0);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #2;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_acc", out_acc, 64'd0);
        check("midrst_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        push_pair(16'h0080, 16'h0300);
        run_vec("post_rst", 0, 0);

        // randomized vectors with input gaps and output stalls
        for (int v = 0; v < 25; v++) begin
            int n;
            n = $urandom_range(1, 8);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 1)
                    push_pair(16'($urandom), 16'($urandom));
                else
                    push_pair(16'($signed(8'($urandom))), 16'($urandom_range(0, 16'h03FF)));
            end
            run_vec("rand", $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
